// File: rtl/mcode_pkg.sv
// rtl/mcode_pkg.sv - shared microcode layout: control-word fields, sequencing codes, states, opcodes
package mcode_pkg;
   localparam int CTRL_LEN   = 15;
   localparam int CTRL_W_DEF = CTRL_LEN;
   localparam int UPC_W_DEF  = 4;

   typedef logic [CTRL_LEN-1:0] ctrl_t;

   localparam int B_PCWRITE     = 14;
   localparam int B_PCWRITECOND = 13;
   localparam int B_IORD        = 12;
   localparam int B_MEMWRITE    = 11;
   localparam int B_IRWRITE     = 10;
   localparam int B_MEMTOREG    = 9;
   localparam int B_PCSRC       = 7;
   localparam int B_ALUOP       = 5;
   localparam int B_ALUSRCB     = 3;
   localparam int B_ALUSRCA     = 2;
   localparam int B_REGWRITE    = 1;
   localparam int B_REGDST      = 0;

   typedef enum logic [1:0] {
      AC_FETCH = 2'd0,
      AC_DISP1 = 2'd1,
      AC_DISP2 = 2'd2,
      AC_SEQ   = 2'd3
   } addrctl_t;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADDR  = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_REXEC    = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_JUMP     = 4'd9;
   localparam logic [3:0] S_EXC      = 4'd10;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   // pw pwc iord mw irw m2r pcsrc aluop srcb srca rw rd
   localparam ctrl_t CW_FETCH   = 15'b1_0_0_0_1_0_00_00_01_0_0_0;
   localparam ctrl_t CW_DECODE  = 15'b0_0_0_0_0_0_00_00_11_0_0_0;
   localparam ctrl_t CW_MEMADDR = 15'b0_0_0_0_0_0_00_00_10_1_0_0;
   localparam ctrl_t CW_MEMREAD = 15'b0_0_1_0_0_0_00_00_00_0_0_0;
   localparam ctrl_t CW_MEMWB   = 15'b0_0_0_0_0_1_00_00_00_0_1_0;
   localparam ctrl_t CW_MEMWR   = 15'b0_0_1_1_0_0_00_00_00_0_0_0;
   localparam ctrl_t CW_REXEC   = 15'b0_0_0_0_0_0_00_10_00_1_0_0;
   localparam ctrl_t CW_ALUWB   = 15'b0_0_0_0_0_0_00_00_00_0_1_1;
   localparam ctrl_t CW_BRANCH  = 15'b0_1_0_0_0_0_01_01_00_1_0_0;
   localparam ctrl_t CW_JUMP    = 15'b1_0_0_0_0_0_10_00_00_0_0_0;
   localparam ctrl_t CW_EXC     = 15'b1_0_0_0_0_0_11_00_00_0_0_0;

   // Architectural-state writes suppressed while a memory access is still pending
   localparam ctrl_t STALL_CLR = ctrl_t'((1 << B_PCWRITE) | (1 << B_PCWRITECOND) |
                                         (1 << B_IRWRITE) | (1 << B_REGWRITE));
endpackage

// File: rtl/mcode_rom.sv
// rtl/mcode_rom.sv - combinational microcode store and opcode dispatch tables
// MCODE_SEQ_EXC_EN: populates microstate 10 and routes illegal opcodes to it
module mcode_rom import mcode_pkg::*; #(
   parameter int UPC_W = UPC_W_DEF
) (
   input  logic [UPC_W-1:0] upc,
   input  logic [5:0]       op,
   output ctrl_t            ctrl,
   output logic             wait_bit,
   output addrctl_t         addrctl,
   output logic             valid,
   output logic [3:0]       disp1,
   output logic [3:0]       disp2
);
`ifdef MCODE_SEQ_EXC_EN
   localparam logic [3:0] ILLEGAL_TGT = S_EXC;
`else
   localparam logic [3:0] ILLEGAL_TGT = S_FETCH;
`endif

   logic       in_range;
   logic [3:0] idx;

   assign in_range = (upc <= UPC_W'(S_EXC));
   assign idx      = upc[3:0];

   always_comb begin
      ctrl     = '0;
      wait_bit = 1'b0;
      addrctl  = AC_FETCH;
      valid    = in_range;
      if (in_range) begin
         case (idx)
            S_FETCH:    begin ctrl = CW_FETCH;   wait_bit = 1'b1; addrctl = AC_SEQ;   end
            S_DECODE:   begin ctrl = CW_DECODE;  addrctl = AC_DISP1;                  end
            S_MEMADDR:  begin ctrl = CW_MEMADDR; addrctl = AC_DISP2;                  end
            S_MEMREAD:  begin ctrl = CW_MEMREAD; wait_bit = 1'b1; addrctl = AC_SEQ;   end
            S_MEMWB:    ctrl = CW_MEMWB;
            S_MEMWRITE: begin ctrl = CW_MEMWR;   wait_bit = 1'b1;                     end
            S_REXEC:    begin ctrl = CW_REXEC;   addrctl = AC_SEQ;                    end
            S_ALUWB:    ctrl = CW_ALUWB;
            S_BRANCH:   ctrl = CW_BRANCH;
            S_JUMP:     ctrl = CW_JUMP;
`ifdef MCODE_SEQ_EXC_EN
            S_EXC:      ctrl = CW_EXC;
`endif
            default:    valid = 1'b0;
         endcase
      end
   end

   always_comb begin
      case (op)
         OP_RTYPE:     disp1 = S_REXEC;
         OP_LW, OP_SW: disp1 = S_MEMADDR;
         OP_BEQ:       disp1 = S_BRANCH;
         OP_J:         disp1 = S_JUMP;
         default:      disp1 = ILLEGAL_TGT;
      endcase
      case (op)
         OP_LW:   disp2 = S_MEMREAD;
         OP_SW:   disp2 = S_MEMWRITE;
         default: disp2 = ILLEGAL_TGT;
      endcase
   end
endmodule

// File: rtl/mcode_seq.sv
// rtl/mcode_seq.sv - microcoded multicycle control sequencer with stall masking and retire counter
// MCODE_SEQ_EXC_EN: illegal opcodes trap to an exception microstate and raise exc
module mcode_seq import mcode_pkg::*; #(
   parameter int UPC_W  = UPC_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        op,
   input  logic              mem_ready,
   output logic [CTRL_W-1:0] ctrl,
   output logic [UPC_W-1:0]  upc,
   output logic              exc,
   output logic [CNT_W-1:0]  instr_count
);
   ctrl_t      rom_ctrl;
   logic       wait_bit;
   logic       valid;
   addrctl_t   addrctl;
   logic [3:0] disp1;
   logic [3:0] disp2;

   logic             hold;
   logic             mask_en;
   logic             advance;
   logic             retire;
   logic [UPC_W-1:0] upc_next;

   mcode_rom #(.UPC_W(UPC_W)) u_rom (
      .upc      (upc),
      .op       (op),
      .ctrl     (rom_ctrl),
      .wait_bit (wait_bit),
      .addrctl  (addrctl),
      .valid    (valid),
      .disp1    (disp1),
      .disp2    (disp2)
   );

   assign hold    = wait_bit & ~mem_ready;
   // While held in reset the fetch word is presented as not-yet-ready
   assign mask_en = wait_bit & (~mem_ready | ~reset);
   assign advance = ~hold;
   assign retire  = advance & valid & (addrctl == AC_FETCH);
   assign ctrl    = mask_en ? (rom_ctrl & ~STALL_CLR) : rom_ctrl;

`ifdef MCODE_SEQ_EXC_EN
   assign exc = (upc == UPC_W'(S_EXC));
`else
   assign exc = 1'b0;
`endif

   always_comb begin
      upc_next = '0;
      if (valid) begin
         case (addrctl)
            AC_FETCH: upc_next = '0;
            AC_DISP1: upc_next = UPC_W'(disp1);
            AC_DISP2: upc_next = UPC_W'(disp2);
            default:  upc_next = upc + UPC_W'(1);
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         upc         <= '0;
         instr_count <= '0;
      end else begin
         if (advance)
            upc <= upc_next;
         if (retire)
            instr_count <= instr_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_mcode_seq.sv
// tb/tb_mcode_seq.sv - scoreboard bench for mcode_seq; follows MCODE_SEQ_EXC_EN when defined
module tb_mcode_seq;
   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  op;
   logic        mem_ready;
   logic [14:0] ctrl;
   logic [3:0]  upc;
   logic        exc;
   logic [15:0] instr_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  upc;
      logic [14:0] ctrl;
      logic        exc;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [15:0] e_cnt;

   localparam logic [14:0] W_FETCH   = 15'b1_0_0_0_1_0_00_00_01_0_0_0;
   localparam logic [14:0] W_DECODE  = 15'b0_0_0_0_0_0_00_00_11_0_0_0;
   localparam logic [14:0] W_MEMADDR = 15'b0_0_0_0_0_0_00_00_10_1_0_0;
   localparam logic [14:0] W_MEMREAD = 15'b0_0_1_0_0_0_00_00_00_0_0_0;
   localparam logic [14:0] W_MEMWB   = 15'b0_0_0_0_0_1_00_00_00_0_1_0;
   localparam logic [14:0] W_MEMWR   = 15'b0_0_1_1_0_0_00_00_00_0_0_0;
   localparam logic [14:0] W_REXEC   = 15'b0_0_0_0_0_0_00_10_00_1_0_0;
   localparam logic [14:0] W_ALUWB   = 15'b0_0_0_0_0_0_00_00_00_0_1_1;
   localparam logic [14:0] W_BRANCH  = 15'b0_1_0_0_0_0_01_01_00_1_0_0;
   localparam logic [14:0] W_JUMP    = 15'b1_0_0_0_0_0_10_00_00_0_0_0;
   localparam logic [14:0] W_EXC     = 15'b1_0_0_0_0_0_11_00_00_0_0_0;

   mcode_seq dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .mem_ready   (mem_ready),
      .ctrl        (ctrl),
      .upc         (upc),
      .exc         (exc),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   // pcwrite, pcwritecond, irwrite, regwrite dropped during a memory stall
   function automatic logic [14:0] stl(input logic [14:0] w);
      return w & 15'b001101111111101;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic step(input logic rdy, input logic [3:0] u, input logic [14:0] c, input logic x);
      mem_ready = rdy;
      sb.push_back('{upc: u, ctrl: c, exc: x, cnt: e_cnt});
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk("upc",   32'(upc),         32'(mon_e.upc));
         chk("ctrl",  32'(ctrl),        32'(mon_e.ctrl));
         chk("exc",   32'(exc),         32'(mon_e.exc));
         chk("count", 32'(instr_count), 32'(mon_e.cnt));
      end
   end

   initial begin
      reset     = 1'b0;
      op        = 6'h00;
      mem_ready = 1'b0;
      e_cnt     = '0;
      #12;
      chk("rst_upc",      32'(upc),         32'd0);
      chk("rst_count",    32'(instr_count), 32'd0);
      chk("rst_exc",      32'(exc),         32'd0);
      chk("rst_ctrl_nr",  32'(ctrl),        32'(stl(W_FETCH)));
      mem_ready = 1'b1;
      #1;
      chk("rst_ctrl_rdy", 32'(ctrl),        32'(stl(W_FETCH)));
      @(posedge clk);
      #1;
      reset = 1'b1;

      // lw, no stalls
      op = 6'h23;
      step(1'b1, 4'd0, W_FETCH,   1'b0);
      step(1'b1, 4'd1, W_DECODE,  1'b0);
      step(1'b1, 4'd2, W_MEMADDR, 1'b0);
      step(1'b1, 4'd3, W_MEMREAD, 1'b0);
      step(1'b1, 4'd4, W_MEMWB,   1'b0);
      e_cnt++;

      // sw, three stall cycles in memwrite; decode ignores mem_ready
      op = 6'h2B;
      step(1'b1, 4'd0, W_FETCH,   1'b0);
      step(1'b0, 4'd1, W_DECODE,  1'b0);
      step(1'b1, 4'd2, W_MEMADDR, 1'b0);
      repeat (3) step(1'b0, 4'd5, W_MEMWR, 1'b0);
      step(1'b1, 4'd5, W_MEMWR,   1'b0);
      e_cnt++;

      // R-type with a two-cycle fetch stall
      op = 6'h00;
      step(1'b0, 4'd0, stl(W_FETCH), 1'b0);
      step(1'b0, 4'd0, stl(W_FETCH), 1'b0);
      step(1'b1, 4'd0, W_FETCH,  1'b0);
      step(1'b0, 4'd1, W_DECODE, 1'b0);
      step(1'b0, 4'd6, W_REXEC,  1'b0);
      step(1'b0, 4'd7, W_ALUWB,  1'b0);
      e_cnt++;

      op = 6'h04;
      step(1'b1, 4'd0, W_FETCH,  1'b0);
      step(1'b1, 4'd1, W_DECODE, 1'b0);
      step(1'b0, 4'd8, W_BRANCH, 1'b0);
      e_cnt++;

      op = 6'h02;
      step(1'b1, 4'd0, W_FETCH,  1'b0);
      step(1'b1, 4'd1, W_DECODE, 1'b0);
      step(1'b1, 4'd9, W_JUMP,   1'b0);
      e_cnt++;

      // asynchronous reset while stalled in memread with count at 5
      op = 6'h23;
      step(1'b1, 4'd0, W_FETCH,   1'b0);
      step(1'b1, 4'd1, W_DECODE,  1'b0);
      step(1'b1, 4'd2, W_MEMADDR, 1'b0);
      step(1'b0, 4'd3, stl(W_MEMREAD), 1'b0);
      chk("pre_rst_upc",   32'(upc),         32'd3);
      chk("pre_rst_count", 32'(instr_count), 32'h5);
      #2;
      reset = 1'b0;
      #1;
      chk("async_upc",   32'(upc),         32'd0);
      chk("async_count", 32'(instr_count), 32'd0);
      chk("async_ctrl",  32'(ctrl),        32'(stl(W_FETCH)));
      mem_ready = 1'b1;
      #1;
      chk("async_ctrl_rdy", 32'(ctrl), 32'(stl(W_FETCH)));
      @(posedge clk);
      #1;
      reset = 1'b1;
      e_cnt = '0;

      // illegal opcode
      op = 6'h3F;
      step(1'b0, 4'd0, stl(W_FETCH), 1'b0);
      step(1'b1, 4'd0, W_FETCH,  1'b0);
      step(1'b1, 4'd1, W_DECODE, 1'b0);
`ifdef MCODE_SEQ_EXC_EN
      step(1'b1, 4'd10, W_EXC,   1'b1);
      e_cnt++;
`endif
      step(1'b1, 4'd0, W_FETCH,  1'b0);

      // unused microstate returns to fetch with ctrl zero and no retire
      force dut.upc = 4'd12;
      #1 release dut.upc;
      step(1'b1, 4'd12, 15'd0, 1'b0);

      // counter wraps from all-ones
      force dut.instr_count = 16'hFFFF;
      #1 release dut.instr_count;
      e_cnt = 16'hFFFF;
      op = 6'h02;
      step(1'b1, 4'd0, W_FETCH,  1'b0);
      step(1'b1, 4'd1, W_DECODE, 1'b0);
      step(1'b1, 4'd9, W_JUMP,   1'b0);
      e_cnt++;
      step(1'b1, 4'd0, W_FETCH,  1'b0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
